mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Two-port arbiter and sequencer for the DLX pipeline's single memory/IO bus. Accepts requests from the instruction-fetch port and the data (load/store) port. Grants one port at a time, drives the shared bus that feeds `chip_select` and the slaves, and inserts RAM wait states. Returns one-cycle acknowledges with read data.

## Interface
Parameters:
- `RAM_WAIT`, default 1: extra cycles per RAM access, range 0..15.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `if_req` in 1: fetch request, held until `if_ack`.
- `if_addr` in ADDR_W: fetch address, stable while `if_req`.
- `if_ack` out 1: one-cycle completion pulse.
- `if_rdata` out DATA_W: fetch data, valid only while `if_ack`.
- `dm_req` in 1: data request, held until `dm_ack`.
- `dm_we` in 1: 1 = store, 0 = load; stable while `dm_req`.
- `dm_addr` in ADDR_W: data address, stable while `dm_req`.
- `dm_wdata` in DATA_W: store data, stable while `dm_req`.
- `dm_ack` out 1: one-cycle completion pulse.
- `dm_rdata` out DATA_W: load data, valid only while `dm_ack`.
- `bus_valid` out 1: access in progress on the shared bus.
- `bus_we` out 1: write strobe, only ever high together with `bus_valid`.
- `bus_addr` out ADDR_W: latched address, feeds `chip_select`.
- `bus_wdata` out DATA_W: latched store data.
- `bus_rdata` in DATA_W: addressed slave's read data, already muxed downstream.

## Operation
- FSM has two states, IDLE and ACCESS. Registered state: `owner` (IF/DM), `last_owner`, wait counter `cnt` (4 bit), and the latched `bus_addr`, `bus_wdata`, `bus_we`.
- **Region decode:** an address below `PERIPH_LIMIT` (8) is a peripheral, which completes with 0 wait. Any other address is RAM and loads `cnt = RAM_WAIT`.
- **IDLE:**
  - If any request is high, grant one port.
  - Latch that port's addr/wdata/we. For IF, `we` is forced to 0.
  - Load `cnt` from the region decode and go to ACCESS.
- **Arbitration on a tie** (both requests high in IDLE): grant the port that is not `last_owner`, i.e. round robin.
- **ACCESS:**
  - `bus_valid` = 1.
  - While `cnt != 0`, decrement `cnt`.
  - When `cnt == 0`, the access completes this cycle:
    - `ack` for `owner` = 1.
    - `rdata` = `bus_rdata`, combinational passthrough, valid for both ports only under their ack.
    - `last_owner <= owner`.
- **Completion handoff:**
  - If the *other* port's request is high, latch it and stay in ACCESS. This is back-to-back with no bubble.
  - Otherwise go to IDLE.
  - The just-acked port is excluded from arbitration in its ack cycle, since its request may still be high that cycle.
- Stores to read-only peripherals (switches, buttons) complete normally. The write is ignored by the slave.
- IF requests to peripheral addresses are legal and complete with 0 wait.

## Timing
- **Reset values** (asynchronous, while `rst_n` = 0):
  - state = IDLE, `owner` = IF, `last_owner` = IF, so the first tie goes to DM.
  - `cnt` = 0, `bus_valid` = 0, `bus_we` = 0, `bus_addr` = 0, `bus_wdata` = 0.
  - `if_ack` = 0, `dm_ack` = 0.
- **Latency from IDLE:** request sampled at edge N.
  - Peripheral access: ack during cycle N+1.
  - RAM access: ack during cycle N+1+RAM_WAIT.
- **Back-to-back, different ports:** the second access's first ACCESS cycle immediately follows the first ack cycle.
- **Back-to-back, same port:** at least one IDLE cycle between the two accesses.
- **Acks:** derived from registered state only, never from current-cycle requests.
  - Each ack lasts exactly one cycle.
  - `if_ack` and `dm_ack` are never high together.
- **Reset mid-access:** the access is aborted, all outputs return to reset values, and no ack is issued.
- **Protocol violation:** a request dropping before its ack is ignored. The latched access still completes and acks.

## Structure
- Package `dlx_bus_pkg` holds:
  - `owner_e` {OWN_IF, OWN_DM};
  - `arb_state_e` {ST_IDLE, ST_ACCESS};
  - `localparam PERIPH_LIMIT = 8`, shared with `chip_select`'s region boundary.
- No sub-module. The region compare is inline. `chip_select` stays downstream on `bus_addr`, outside this block.

## Test plan
- **Reset:** assert `rst_n`=0 during a RAM access with `RAM_WAIT`=3 → all bus outputs and acks are 0 immediately, and no ack follows release.
- **Peripheral load:** `dm_req`, `dm_addr`=2, `bus_rdata`=0xA5 → `dm_ack`=1 one cycle after the request edge, with `dm_rdata`=0xA5.
- **RAM fetch:** `RAM_WAIT`=2, `if_addr`=0x100 → `bus_valid` high for 3 cycles, then `if_ack` in the third, with `bus_we`=0 throughout.
- **Tie after reset:** both requests high from reset → DM is served first. IF starts the cycle after `dm_ack` with no bubble, then `if_ack`.
- **Sustained contention:** both requests reissued continuously for 8 accesses → grants strictly alternate DM, IF, DM, …
- **Store:** `dm_we`=1, `dm_addr`=0x40, `dm_wdata`=0xDEADBEEF → `bus_we`=1 and `bus_wdata`=0xDEADBEEF for all 1+RAM_WAIT ACCESS cycles, then `bus_we`=0 after `dm_ack`.

Source files
------------

// File: rtl/dlx_bus_pkg.sv
// dlx_bus_pkg: shared types and region boundary for the DLX memory/IO bus
package dlx_bus_pkg;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;
  typedef enum logic {ST_IDLE, ST_ACCESS} arb_state_e;
  localparam int PERIPH_LIMIT = 8;
endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin fetch/data arbiter and wait-state sequencer for the shared bus
module mem_bus_arbiter
  import dlx_bus_pkg::*;
#(
  parameter int RAM_WAIT = 1,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
);
  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d, last_q, last_d, gnt;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d, load, done;

  assign done      = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
  assign if_ack    = done && (owner_q == OWN_IF);
  assign dm_ack    = done && (owner_q == OWN_DM);
  assign if_rdata  = if_ack ? bus_rdata : '0;
  assign dm_rdata  = dm_ack ? bus_rdata : '0;
  assign bus_valid = (state_q == ST_ACCESS);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

  // Arbitrate in IDLE or at completion (excluding the just-acked port), count wait states, latch the granted access
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    load    = 1'b0;
    gnt     = OWN_IF;
    if (state_q == ST_IDLE) begin
      load = if_req || dm_req;
      gnt  = (if_req && dm_req) ? ((last_q == OWN_IF) ? OWN_DM : OWN_IF) : (dm_req ? OWN_DM : OWN_IF);
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      last_d = owner_q;
      gnt    = (owner_q == OWN_IF) ? OWN_DM : OWN_IF;
      load   = (owner_q == OWN_IF) ? dm_req : if_req;
      if (!load) begin
        state_d = ST_IDLE;
        we_d    = 1'b0;
      end
    end
    if (load) begin
      state_d = ST_ACCESS;
      owner_d = gnt;
      addr_d  = (gnt == OWN_DM) ? dm_addr : if_addr;
      wdata_d = (gnt == OWN_DM) ? dm_wdata : '0;
      we_d    = (gnt == OWN_DM) && dm_we;
      cnt_d   = (addr_d < ADDR_W'(PERIPH_LIMIT)) ? 4'd0 : 4'(RAM_WAIT);
    end
  end

  // State and latched bus registers; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IF;
      last_q  <= OWN_IF;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end
endmodule
